// File: rtl/multdiv_sched_if.sv
// Bundle between the execute stage, the multiply/divide scheduler and the iterative
// mult/div unit. The scheduler connects through the slave modport.
interface multdiv_sched_if #(
  parameter int TAG_W = 5
);
  // Request handshake: an operation transfers on a rising edge where op_valid and
  // op_ready are both high; op_valid, op_is_div, op_a, op_b and op_tag must hold
  // steady until that edge, and op_ready never depends on op_valid.
  logic             op_valid;
  logic             op_is_div;
  logic [31:0]      op_a;
  logic [31:0]      op_b;
  logic [TAG_W-1:0] op_tag;
  logic             flush;
  logic             op_ready;
  logic             stall;

  logic             md_ctrl_MULT;
  logic             md_ctrl_DIV;
  logic [31:0]      md_operandA;
  logic [31:0]      md_operandB;
  logic [31:0]      md_result;
  logic             md_exception;
  logic             md_resultRDY;

  logic             wb_valid;
  logic [31:0]      wb_data;
  logic [TAG_W-1:0] wb_tag;
  logic             wb_exception;

  logic [2:0]       dbg_state;

  modport slave (
    input  op_valid, op_is_div, op_a, op_b, op_tag, flush,
    input  md_result, md_exception, md_resultRDY,
    output op_ready, stall,
    output md_ctrl_MULT, md_ctrl_DIV, md_operandA, md_operandB,
    output wb_valid, wb_data, wb_tag, wb_exception,
    output dbg_state
  );

  modport master (
    output op_valid, op_is_div, op_a, op_b, op_tag, flush,
    output md_result, md_exception, md_resultRDY,
    input  op_ready, stall,
    input  md_ctrl_MULT, md_ctrl_DIV, md_operandA, md_operandB,
    input  wb_valid, wb_data, wb_tag, wb_exception,
    input  dbg_state
  );
endinterface

// File: rtl/multdiv_sched.sv
// Sequences one multiply/divide at a time through an iterative unit: latch, start pulse,
// wait for the result (with a timeout), one-cycle writeback; flush drains the busy unit.
module multdiv_sched #(
  parameter int TAG_W   = 5,
  parameter int TIMEOUT = 64
) (
  input  logic             clock,
  input  logic             reset,
  multdiv_sched_if.slave   bus
);

  localparam int                CNT_W    = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_DONE  = 3'd3,
    S_DRAIN = 3'd4
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [31:0]      r_a;
  logic [31:0]      r_b;
  logic [TAG_W-1:0] r_tag;
  logic             r_is_div;
  logic [CNT_W-1:0] r_cnt;
  logic [31:0]      r_wb_data;
  logic [TAG_W-1:0] r_wb_tag;
  logic             r_wb_exc;

  logic             w_ready;
  logic             w_accept;
  logic             w_capture;
  logic             w_timeout;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // The unit raises md_resultRDY while idle, so it is only meaningful in WAIT and DRAIN.
  always_comb begin
    w_next    = r_state;
    w_accept  = 1'b0;
    w_capture = 1'b0;
    w_timeout = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.op_valid && !bus.flush) begin
          w_accept = 1'b1;
          w_next   = S_ISSUE;
        end
      end
      S_ISSUE: w_next = bus.flush ? S_DRAIN : S_WAIT;
      S_WAIT: begin
        if (bus.flush) begin
          w_next = S_DRAIN;
        end else if (bus.md_resultRDY) begin
          w_capture = 1'b1;
          w_next    = S_DONE;
        end else if (r_cnt == CNT_LAST) begin
          w_timeout = 1'b1;
          w_next    = S_DONE;
        end
      end
      S_DONE:  w_next = S_IDLE;
      S_DRAIN: if (bus.md_resultRDY) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_a      <= '0;
      r_b      <= '0;
      r_tag    <= '0;
      r_is_div <= 1'b0;
    end else if (w_accept) begin
      r_a      <= bus.op_a;
      r_b      <= bus.op_b;
      r_tag    <= bus.op_tag;
      r_is_div <= bus.op_is_div;
    end
  end

  // Cleared while in ISSUE so the first WAIT cycle sees zero.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)                  r_cnt <= '0;
    else if (r_state == S_ISSUE) r_cnt <= '0;
    else if (r_state == S_WAIT)  r_cnt <= r_cnt + CNT_W'(1);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_wb_data <= '0;
      r_wb_tag  <= '0;
      r_wb_exc  <= 1'b0;
    end else if (w_capture) begin
      r_wb_data <= bus.md_result;
      r_wb_tag  <= r_tag;
      r_wb_exc  <= bus.md_exception;
    end else if (w_timeout) begin
      r_wb_data <= '0;
      r_wb_tag  <= r_tag;
      r_wb_exc  <= 1'b1;
    end
  end

  assign w_ready          = (r_state == S_IDLE);
  assign bus.op_ready     = w_ready;
  assign bus.stall        = (r_state != S_IDLE) | (bus.op_valid & ~w_ready);
  assign bus.md_ctrl_MULT = (r_state == S_ISSUE) & ~r_is_div;
  assign bus.md_ctrl_DIV  = (r_state == S_ISSUE) &  r_is_div;
  assign bus.md_operandA  = r_a;
  assign bus.md_operandB  = r_b;
  assign bus.wb_valid     = (r_state == S_DONE) & ~bus.flush;
  assign bus.wb_data      = r_wb_data;
  assign bus.wb_tag       = r_wb_tag;
  assign bus.wb_exception = r_wb_exc;
  assign bus.dbg_state    = r_state;

endmodule

// File: tb/tb_multdiv_sched.sv
// Bench for multdiv_sched: a latency-programmable mult/div unit model, directed scenarios
// and randomized operations checked against an arithmetic/timing reference model.
module tb_multdiv_sched;
  localparam int TAG_W   = 5;
  localparam int T_MAIN  = 64;
  localparam int T_SHORT = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  multdiv_sched_if #(.TAG_W(TAG_W)) m ();
  multdiv_sched_if #(.TAG_W(TAG_W)) m8 ();

  multdiv_sched #(.TAG_W(TAG_W), .TIMEOUT(T_MAIN)) dut (
    .clock (clk),
    .reset (rst),
    .bus   (m.slave)
  );

  multdiv_sched #(.TAG_W(TAG_W), .TIMEOUT(T_SHORT)) dut8 (
    .clock (clk),
    .reset (rst),
    .bus   (m8.slave)
  );

  // ---------------- unit model: result ready u_lat cycles after the start pulse ----------------
  int          u_lat = 1;
  int          u_busy;
  logic [31:0] u_res;
  logic        u_exc;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      u_busy <= 0;
      u_res  <= '0;
      u_exc  <= 1'b0;
    end else if (m.md_ctrl_MULT || m.md_ctrl_DIV) begin
      u_busy <= u_lat;
      if (m.md_ctrl_DIV) begin
        if (m.md_operandB == 32'd0) begin
          u_res <= '0;
          u_exc <= 1'b1;
        end else begin
          u_res <= $signed(m.md_operandA) / $signed(m.md_operandB);
          u_exc <= 1'b0;
        end
      end else begin
        u_res <= m.md_operandA * m.md_operandB;
        u_exc <= 1'b0;
      end
    end else if (u_busy > 0) begin
      u_busy <= u_busy - 1;
    end
  end

  assign m.md_result    = u_res;
  assign m.md_exception = u_exc;
  assign m.md_resultRDY = (u_busy <= 1);

  // The short-timeout instance sees a unit that never answers.
  assign m8.md_result    = 32'hDEADBEEF;
  assign m8.md_exception = 1'b0;
  assign m8.md_resultRDY = 1'b0;

  // ---------------- monitors ----------------
  int n_mult = 0;
  int n_div  = 0;
  int n_wb   = 0;
  int n_wb8  = 0;
  int n_both = 0;

  always @(negedge clk) begin
    if (m.md_ctrl_MULT) n_mult <= n_mult + 1;
    if (m.md_ctrl_DIV)  n_div  <= n_div + 1;
    if (m.md_ctrl_MULT && m.md_ctrl_DIV) n_both <= n_both + 1;
    if (m.wb_valid)     n_wb   <= n_wb + 1;
    if (m8.wb_valid)    n_wb8  <= n_wb8 + 1;
  end

  logic [31:0] exp_q[$];

  // ---------------- reference model ----------------
  // Writeback expected from an op that the unit finishes `lat` cycles after its start,
  // under a scheduler timeout of `tmo` WAIT cycles.
  function automatic void model(input logic is_div, input logic [31:0] a, input logic [31:0] b,
                                input int lat, input int tmo,
                                output logic [31:0] d, output logic e, output int n_wait);
    n_wait = (lat > tmo) ? tmo : lat;
    if (lat > tmo) begin
      d = '0; e = 1'b1;
    end else if (is_div && b == 32'd0) begin
      d = '0; e = 1'b1;
    end else if (is_div) begin
      d = $signed(a) / $signed(b); e = 1'b0;
    end else begin
      d = a * b; e = 1'b0;
    end
  endfunction

  // ---------------- driver tasks ----------------
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic run_op(input logic is_div, input logic [31:0] a, input logic [31:0] b,
                        input logic [TAG_W-1:0] tag, input int lat,
                        output int acc_cyc, output int wb_cyc, output int lat_obs,
                        output logic [31:0] d, output logic [TAG_W-1:0] t, output logic e,
                        output int dm, output int dd, output bit got);
    int w;
    int m0;
    int d0;
    m0 = n_mult;
    d0 = n_div;
    u_lat = lat;
    m.op_valid  = 1'b1;
    m.op_is_div = is_div;
    m.op_a      = a;
    m.op_b      = b;
    m.op_tag    = tag;
    w = 0;
    while (!m.op_ready && w < 100) begin
      step();
      w++;
    end
    acc_cyc = cyc;
    step();
    m.op_valid = 1'b0;
    m.op_a     = $urandom;
    m.op_b     = $urandom;
    lat_obs = 1;
    got = 1'b0;
    d = '0; t = '0; e = 1'b0;
    while (lat_obs < 200) begin
      if (m.wb_valid) begin
        got = 1'b1;
        d = m.wb_data;
        t = m.wb_tag;
        e = m.wb_exception;
        break;
      end
      step();
      lat_obs++;
    end
    wb_cyc = cyc;
    dm = n_mult - m0;
    dd = n_div - d0;
  endtask

  // ---------------- scenarios ----------------
  int          acc, wbc, lo, dm, dd;
  logic [31:0] d;
  logic [TAG_W-1:0] t;
  logic        e;
  bit          got;

  task automatic test_reset();
    int rel;
    m.op_valid = 1'b1; m.op_is_div = 1'b0; m.op_a = 32'h1234; m.op_b = 32'h5678;
    m.op_tag = 5'd9; m.flush = 1'b0;
    step(); step();
    n_checks++;
    if ({m.op_ready, m.stall, m.md_ctrl_MULT, m.md_ctrl_DIV, m.wb_valid, m.wb_exception} !== 6'b100000) begin
      n_errors++;
      $display("FAIL reset_ctrl got %b want 100000",
               {m.op_ready, m.stall, m.md_ctrl_MULT, m.md_ctrl_DIV, m.wb_valid, m.wb_exception});
    end
    n_checks++;
    if ({m.md_operandA, m.md_operandB, m.wb_data, m.wb_tag} !== '0) begin
      n_errors++;
      $display("FAIL reset_data got %h %h %h %h want all 0", m.md_operandA, m.md_operandB, m.wb_data, m.wb_tag);
    end
    n_checks++;
    if (m8.op_ready !== 1'b1) begin
      n_errors++; $display("FAIL reset_ready8 got %b want 1", m8.op_ready);
    end
    rst = 1'b0;
    rel = cyc;
    run_op(1'b0, 32'd3, 32'hFFFFFFFC, 5'd1, 5, acc, wbc, lo, d, t, e, dm, dd, got);
    n_checks++;
    if (acc !== rel) begin n_errors++; $display("FAIL first_edge_accept got %0d want %0d", acc, rel); end
    n_checks++;
    if (got !== 1'b1 || d !== 32'hFFFFFFF4 || lo !== 7) begin
      n_errors++; $display("FAIL mult_after_reset got wb=%b d=%h lat=%0d want 1 fffffff4 7", got, d, lo);
    end
    step();
  endtask

  task automatic test_div();
    int wb0;
    wb0 = n_wb;
    run_op(1'b1, 32'd100, 32'd7, 5'd3, 33, acc, wbc, lo, d, t, e, dm, dd, got);
    n_checks++;
    if (lo !== 35) begin n_errors++; $display("FAIL div_latency got %0d want 35", lo); end
    n_checks++;
    if (d !== 32'd14 || t !== 5'd3 || e !== 1'b0) begin
      n_errors++; $display("FAIL div_100_7 got d=%0d t=%0d e=%b want 14 3 0", d, t, e);
    end
    n_checks++;
    if (dd !== 1 || dm !== 0) begin n_errors++; $display("FAIL div_pulses got div=%0d mult=%0d want 1 0", dd, dm); end
    step();
    n_checks++;
    if (n_wb - wb0 !== 1) begin n_errors++; $display("FAIL wb_one_cycle got %0d want 1", n_wb - wb0); end
    n_checks++;
    if (m.md_operandA !== 32'd100 || m.md_operandB !== 32'd7 || m.wb_data !== 32'd14) begin
      n_errors++; $display("FAIL held_values got %h %h %h want 64 7 e", m.md_operandA, m.md_operandB, m.wb_data);
    end
    run_op(1'b1, 32'hFFFFFF9C, 32'd7, 5'd4, 33, acc, wbc, lo, d, t, e, dm, dd, got);
    n_checks++;
    if (d !== 32'hFFFFFFF2 || e !== 1'b0) begin n_errors++; $display("FAIL div_neg got %h e=%b want fffffff2 0", d, e); end
    step();
    run_op(1'b1, 32'd5, 32'd0, 5'd5, 1, acc, wbc, lo, d, t, e, dm, dd, got);
    n_checks++;
    if (lo !== 3 || d !== 32'd0 || e !== 1'b1 || t !== 5'd5) begin
      n_errors++; $display("FAIL div_by_zero got lat=%0d d=%h e=%b t=%0d want 3 0 1 5", lo, d, e, t);
    end
    step();
  endtask

  task automatic test_back_to_back();
    int wb_first;
    run_op(1'b1, 32'd100, 32'd7, 5'd6, 10, acc, wbc, lo, d, t, e, dm, dd, got);
    wb_first = wbc;
    m.op_valid = 1'b1;
    n_checks++;
    if (m.stall !== 1'b1 || m.op_ready !== 1'b0) begin
      n_errors++; $display("FAIL stall_in_done got stall=%b ready=%b want 1 0", m.stall, m.op_ready);
    end
    run_op(1'b0, 32'd6, 32'd7, 5'd7, 4, acc, wbc, lo, d, t, e, dm, dd, got);
    n_checks++;
    if (acc - wb_first !== 1) begin n_errors++; $display("FAIL b2b_accept_gap got %0d want 1", acc - wb_first); end
    n_checks++;
    if (d !== 32'd42 || t !== 5'd7 || lo !== 6) begin
      n_errors++; $display("FAIL mult_6_7 got d=%0d t=%0d lat=%0d want 42 7 6", d, t, lo);
    end
    n_checks++;
    if (dm !== 1 || dd !== 0) begin n_errors++; $display("FAIL mult_pulses got mult=%0d div=%0d want 1 0", dm, dd); end
    step();
  endtask

  task automatic test_timeout_priority();
    run_op(1'b0, 32'd11, 32'd13, 5'd8, T_MAIN, acc, wbc, lo, d, t, e, dm, dd, got);
    n_checks++;
    if (lo !== T_MAIN + 2 || d !== 32'd143 || e !== 1'b0) begin
      n_errors++; $display("FAIL ready_beats_timeout got lat=%0d d=%0d e=%b want %0d 143 0", lo, d, e, T_MAIN + 2);
    end
    step();
    run_op(1'b0, 32'd11, 32'd13, 5'd9, T_MAIN + 1, acc, wbc, lo, d, t, e, dm, dd, got);
    n_checks++;
    if (lo !== T_MAIN + 2 || d !== 32'd0 || e !== 1'b1 || t !== 5'd9) begin
      n_errors++; $display("FAIL timeout_main got lat=%0d d=%h e=%b t=%0d want %0d 0 1 9", lo, d, e, t, T_MAIN + 2);
    end
    repeat (3) step();
  endtask

  task automatic test_flush();
    int wb0, div0, drain;
    logic [31:0] wd0;
    // flush in IDLE blocks the accept
    div0 = n_div;
    m.op_valid = 1'b1; m.op_is_div = 1'b1; m.op_a = 32'd9; m.op_b = 32'd3; m.op_tag = 5'd2;
    m.flush = 1'b1;
    step();
    m.flush = 1'b0; m.op_valid = 1'b0;
    step();
    n_checks++;
    if (m.op_ready !== 1'b1 || n_div !== div0) begin
      n_errors++; $display("FAIL flush_idle got ready=%b pulses=%0d want 1 0", m.op_ready, n_div - div0);
    end
    // flush in WAIT cycle 10 of a 33-cycle divide
    wb0 = n_wb;
    wd0 = m.wb_data;
    u_lat = 33;
    m.op_valid = 1'b1; m.op_is_div = 1'b1; m.op_a = 32'd1000; m.op_b = 32'd9; m.op_tag = 5'd12;
    step();
    m.op_valid = 1'b0;
    repeat (10) step();
    m.flush = 1'b1;
    step();
    m.flush = 1'b0;
    div0 = n_div;
    drain = 0;
    while (!m.op_ready && drain < 100) begin
      drain++;
      step();
    end
    n_checks++;
    if (drain !== 33 - 10) begin n_errors++; $display("FAIL drain_length got %0d want %0d", drain, 33 - 10); end
    n_checks++;
    if (n_wb - wb0 !== 0 || m.wb_data !== wd0 || n_div !== div0) begin
      n_errors++; $display("FAIL flushed_no_wb got wb=%0d data=%h pulses=%0d want 0 %h 0", n_wb - wb0, m.wb_data, n_div - div0, wd0);
    end
    run_op(1'b1, 32'd77, 32'hFFFFFFF9, 5'd13, 20, acc, wbc, lo, d, t, e, dm, dd, got);
    n_checks++;
    if (got !== 1'b1 || d !== 32'hFFFFFFF5 || t !== 5'd13 || e !== 1'b0 || lo !== 22) begin
      n_errors++; $display("FAIL div_after_flush got wb=%b d=%h t=%0d e=%b lat=%0d want 1 fffffff5 13 0 22", got, d, t, e, lo);
    end
    step();
  endtask

  task automatic test_stuck_unit();
    int k, wb80;
    logic [31:0] ed;
    logic        ee;
    int          nw;
    model(1'b1, 32'd50, 32'd5, 1 << 30, T_SHORT, ed, ee, nw);
    m8.op_valid = 1'b1; m8.op_is_div = 1'b1; m8.op_a = 32'd50; m8.op_b = 32'd5; m8.op_tag = 5'd21;
    step();
    m8.op_valid = 1'b0;
    k = 1;
    while (!m8.wb_valid && k < 100) begin
      step();
      k++;
    end
    n_checks++;
    if (k !== nw + 2) begin n_errors++; $display("FAIL t8_latency got %0d want %0d", k, nw + 2); end
    n_checks++;
    if (m8.wb_data !== ed || m8.wb_exception !== ee || m8.wb_tag !== 5'd21) begin
      n_errors++; $display("FAIL t8_payload got d=%h e=%b t=%0d want %h %b 21", m8.wb_data, m8.wb_exception, m8.wb_tag, ed, ee);
    end
    step(); step();
    wb80 = n_wb8;
    m8.op_valid = 1'b1; m8.op_tag = 5'd22;
    step();
    m8.op_valid = 1'b0;
    repeat (4) step();
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (m8.op_ready !== 1'b1 || m8.wb_valid !== 1'b0 || m8.stall !== 1'b0 || m8.md_ctrl_DIV !== 1'b0) begin
      n_errors++; $display("FAIL async_reset got ready=%b wb=%b stall=%b div=%b want 1 0 0 0", m8.op_ready, m8.wb_valid, m8.stall, m8.md_ctrl_DIV);
    end
    step();
    rst = 1'b0;
    repeat (15) step();
    n_checks++;
    if (n_wb8 - wb80 !== 0 || m8.op_ready !== 1'b1) begin
      n_errors++; $display("FAIL reset_drops_op got wb=%0d ready=%b want 0 1", n_wb8 - wb80, m8.op_ready);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 25; i++) begin
      logic             is_div;
      logic [31:0]      a, b, ed, got_d;
      logic [TAG_W-1:0] tag;
      logic             ee;
      int               lat, nw;
      is_div = 1'($urandom_range(0, 1));
      a = $urandom;
      b = ($urandom_range(0, 1) == 0) ? $urandom : 32'($urandom_range(1, 50));
      if (b == 32'd0) b = 32'd1;
      if (a == 32'h80000000 && b == 32'hFFFFFFFF) b = 32'd3;
      tag = TAG_W'($urandom);
      lat = $urandom_range(1, 70);
      model(is_div, a, b, lat, T_MAIN, ed, ee, nw);
      exp_q.push_back(ed);
      run_op(is_div, a, b, tag, lat, acc, wbc, lo, d, t, e, dm, dd, got);
      got_d = exp_q.pop_front();
      n_checks++;
      if (got !== 1'b1 || d !== got_d || e !== ee || t !== tag) begin
        n_errors++; $display("FAIL rand_payload[%0d] got wb=%b d=%h e=%b t=%0d want 1 %h %b %0d", i, got, d, e, t, got_d, ee, tag);
      end
      n_checks++;
      if (lo !== nw + 2) begin n_errors++; $display("FAIL rand_latency[%0d] got %0d want %0d", i, lo, nw + 2); end
      n_checks++;
      if (dm !== (is_div ? 0 : 1) || dd !== (is_div ? 1 : 0) || m.md_operandA !== a || m.md_operandB !== b) begin
        n_errors++; $display("FAIL rand_issue[%0d] got mult=%0d div=%0d A=%h B=%h want %0d %0d %h %h", i, dm, dd, m.md_operandA, m.md_operandB, is_div ? 0 : 1, is_div ? 1 : 0, a, b);
      end
      if ($urandom_range(0, 2) == 0) repeat ($urandom_range(1, 3)) step();
    end
    step();
    n_checks++;
    if (n_both !== 0) begin n_errors++; $display("FAIL both_pulses got %0d want 0", n_both); end
  endtask

  initial begin
    m.op_valid = 1'b0; m.op_is_div = 1'b0; m.op_a = '0; m.op_b = '0; m.op_tag = '0; m.flush = 1'b0;
    m8.op_valid = 1'b0; m8.op_is_div = 1'b0; m8.op_a = '0; m8.op_b = '0; m8.op_tag = '0; m8.flush = 1'b0;
    test_reset();
    test_div();
    test_back_to_back();
    test_timeout_priority();
    test_flush();
    test_stuck_unit();
    test_random();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog cycles=%0d want completion", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
